// File: rtl/stack_defs.sv
// rtl/stack_defs.sv - shared state encoding, default bounds and word counts for the stack unit
package stack_defs;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int SP_INIT_DEFAULT  = 4095;
    localparam int SP_LIMIT_DEFAULT = 0;

    localparam int WORDS_CALL_RET = 1;
    localparam int WORDS_INT_RTI  = 2;

endpackage

// File: rtl/stack_pointer_unit_if.sv
// rtl/stack_pointer_unit_if.sv - request, memory and status signals of the stack pointer unit
interface stack_pointer_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 2
);
    logic              op_valid;
    logic              op_push;
    logic [CNT_W-1:0]  op_words;
    logic              mem_stall;
    logic              err_clr;
    logic              op_ready;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [CNT_W-1:0]  word_idx;
    logic              done;
    logic              ovf;
    logic              unf;

    modport master (
        output op_valid, op_push, op_words, mem_stall, err_clr,
        input  op_ready, sp, mem_addr, mem_en, mem_we, word_idx, done, ovf, unf
    );

    modport slave (
        input  op_valid, op_push, op_words, mem_stall, err_clr,
        output op_ready, sp, mem_addr, mem_en, mem_we, word_idx, done, ovf, unf
    );
endinterface

// File: rtl/sp_bound_check.sv
// rtl/sp_bound_check.sv - per-word address, next SP and bound violation for one stack access
module sp_bound_check #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] sp,
    input  logic              push,
    input  logic [ADDR_W-1:0] sp_lo,
    input  logic [ADDR_W-1:0] sp_hi,
    output logic [ADDR_W-1:0] sp_next,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    // Push is post-decrement (write at sp), pop is pre-increment (read at sp+1).
    always_comb begin
        err     = 1'b0;
        addr    = sp;
        sp_next = sp;
        if (push) begin
            err     = (sp < sp_lo);
            addr    = sp;
            sp_next = err ? sp : sp - ONE;
        end else begin
            err     = (sp >= sp_hi);
            addr    = sp + ONE;
            sp_next = err ? sp : sp + ONE;
        end
    end
endmodule

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - sequenced, bounds-checked stack pointer with one word per cycle
module stack_pointer_unit
    import stack_defs::*;
#(
    parameter int ADDR_W    = 32,
    parameter int SP_INIT   = SP_INIT_DEFAULT,
    parameter int SP_LIMIT  = SP_LIMIT_DEFAULT,
    parameter int MAX_WORDS = WORDS_INT_RTI,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_pointer_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(WORDS_CALL_RET);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_t            state, state_next;
    logic [ADDR_W-1:0] sp_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  idx_q;
    logic              push_q;
    logic              ovf_q, unf_q;

    logic              accept;
    logic              advance;
    logic              last;
    logic [CNT_W-1:0]  words_eff;
    logic [ADDR_W-1:0] sp_next, word_addr;
    logic              bound_err;

    sp_bound_check #(.ADDR_W(ADDR_W)) u_bound (
        .sp      (sp_q),
        .push    (push_q),
        .sp_lo   (ADDR_W'(SP_LIMIT)),
        .sp_hi   (ADDR_W'(SP_INIT)),
        .sp_next (sp_next),
        .addr    (word_addr),
        .err     (bound_err)
    );

    assign accept = bus.op_valid && (state == ST_IDLE);
    assign last   = (idx_q == words_q - CNT_ONE);

    always_comb begin
        words_eff = bus.op_words;
        if (bus.op_words == '0)
            words_eff = CNT_ONE;
        else if (bus.op_words > CNT_MAX)
            words_eff = CNT_MAX;
    end

    always_comb begin
        state_next   = state;
        advance      = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.op_valid)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // An out-of-bounds word is suppressed but still consumes its slot.
                bus.mem_en   = !bound_err;
                bus.mem_we   = push_q;
                bus.mem_addr = word_addr;
                if (!bus.mem_stall) begin
                    advance = 1'b1;
                    if (last) begin
                        bus.done   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sp_q    <= ADDR_W'(SP_INIT);
            words_q <= CNT_ONE;
            idx_q   <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                push_q  <= bus.op_push;
                words_q <= words_eff;
            end
            if (advance) begin
                sp_q  <= sp_next;
                idx_q <= last ? '0 : idx_q + CNT_ONE;
            end
            if (advance && bound_err && push_q)
                ovf_q <= 1'b1;
            else if (bus.err_clr)
                ovf_q <= 1'b0;
            if (advance && bound_err && !push_q)
                unf_q <= 1'b1;
            else if (bus.err_clr)
                unf_q <= 1'b0;
        end
    end

    assign bus.op_ready = (state == ST_IDLE);
    assign bus.sp       = sp_q;
    assign bus.word_idx = idx_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb/tb_stack_pointer_unit.sv - directed scoreboard bench for stack_pointer_unit
module tb_stack_pointer_unit;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
    localparam int INIT   = 4095;

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [CNT_W-1:0]  idx;
        logic              done;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    logic sel = 1'b0;
    logic op_valid = 1'b0;
    logic op_push = 1'b0;
    logic [CNT_W-1:0] op_words = '0;
    logic mem_stall = 1'b0;
    logic err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    logic [ADDR_W-1:0] m_sp;
    int m_lim;

    always #5 clk = ~clk;

    stack_pointer_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus0 ();
    stack_pointer_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus1 ();

    assign bus0.op_valid  = op_valid;
    assign bus0.op_push   = op_push;
    assign bus0.op_words  = op_words;
    assign bus0.mem_stall = mem_stall;
    assign bus0.err_clr   = err_clr;
    assign bus1.op_valid  = op_valid;
    assign bus1.op_push   = op_push;
    assign bus1.op_words  = op_words;
    assign bus1.mem_stall = mem_stall;
    assign bus1.err_clr   = err_clr;

    stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_INIT(INIT), .SP_LIMIT(0),
                         .MAX_WORDS(2), .CNT_W(CNT_W)) dut0 (
        .clk (clk), .rst (rst0), .bus (bus0.slave));

    stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_INIT(INIT), .SP_LIMIT(4094),
                         .MAX_WORDS(2), .CNT_W(CNT_W)) dut1 (
        .clk (clk), .rst (rst1), .bus (bus1.slave));

    logic              o_ready, o_en, o_we, o_done, o_ovf, o_unf;
    logic [ADDR_W-1:0] o_sp, o_addr;
    logic [CNT_W-1:0]  o_idx;

    always_comb begin
        o_ready = sel ? bus1.op_ready : bus0.op_ready;
        o_en    = sel ? bus1.mem_en   : bus0.mem_en;
        o_we    = sel ? bus1.mem_we   : bus0.mem_we;
        o_done  = sel ? bus1.done     : bus0.done;
        o_ovf   = sel ? bus1.ovf      : bus0.ovf;
        o_unf   = sel ? bus1.unf      : bus0.unf;
        o_sp    = sel ? bus1.sp       : bus0.sp;
        o_addr  = sel ? bus1.mem_addr : bus0.mem_addr;
        o_idx   = sel ? bus1.word_idx : bus0.word_idx;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: spec push/pop conventions with bound suppression.
    task automatic expect_op(input logic push, input int words);
        int n;
        exp_t e;
        n = (words == 0) ? 1 : (words > 2 ? 2 : words);
        for (int i = 0; i < n; i++) begin
            e.we   = push;
            e.idx  = CNT_W'(i);
            e.done = (i == n - 1);
            if (push) begin
                e.en   = (int'(m_sp) >= m_lim);
                e.addr = m_sp;
                if (e.en) m_sp = m_sp - 1;
            end else begin
                e.en   = (int'(m_sp) < INIT);
                e.addr = m_sp + 1;
                if (e.en) m_sp = m_sp + 1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_op(input logic push, input int words, input int stall0);
        int guard;
        int stalls_left;
        exp_t e;
        expect_op(push, words);
        stalls_left = stall0;
        tick();
        op_valid = 1'b1;
        op_push  = push;
        op_words = CNT_W'(words);
        #1 check("ready_at_req", 64'(o_ready), 64'd1);
        tick();
        op_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            mem_stall = (stalls_left > 0);
            #1;
            e = exp_q[0];
            check("busy", 64'(o_ready), 64'd0);
            check("mem_en", 64'(o_en), 64'(e.en));
            if (e.en) begin
                check("mem_addr", 64'(o_addr), 64'(e.addr));
                check("mem_we", 64'(o_we), 64'(e.we));
            end
            check("word_idx", 64'(o_idx), 64'(e.idx));
            check("done", 64'(o_done), mem_stall ? 64'd0 : 64'(e.done));
            if (mem_stall) stalls_left--;
            else void'(exp_q.pop_front());
            tick();
            guard++;
        end
        mem_stall = 1'b0;
        if (exp_q.size() != 0) begin
            check("seq_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        #1;
        check("ready_after", 64'(o_ready), 64'd1);
        check("done_after", 64'(o_done), 64'd0);
        check("sp_model", 64'(o_sp), 64'(m_sp));
    endtask

    initial begin
        m_lim = 0;
        m_sp  = ADDR_W'(INIT);
        tick();
        tick();
        rst0 = 1'b1;
        tick();
        #1;
        check("rst_sp", 64'(o_sp), 64'd4095);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        check("rst_unf", 64'(o_unf), 64'd0);
        check("rst_mem_en", 64'(o_en), 64'd0);
        check("rst_idx", 64'(o_idx), 64'd0);

        run_op(1'b1, 1, 0);
        check("push1_sp", 64'(o_sp), 64'd4094);

        run_op(1'b1, 2, 3);
        check("int_sp", 64'(o_sp), 64'd4092);

        run_op(1'b0, 2, 0);
        check("rti_sp", 64'(o_sp), 64'd4094);

        run_op(1'b0, 1, 0);
        check("pop1_sp", 64'(o_sp), 64'd4095);

        run_op(1'b1, 3, 0);
        check("clamp_sp", 64'(o_sp), 64'd4093);

        run_op(1'b0, 0, 0);
        check("zero_words_sp", 64'(o_sp), 64'd4094);

        run_op(1'b0, 1, 1);
        check("pop_top_sp", 64'(o_sp), 64'd4095);
        check("no_unf_yet", 64'(o_unf), 64'd0);

        run_op(1'b0, 1, 0);
        check("unf_set", 64'(o_unf), 64'd1);
        check("unf_sp", 64'(o_sp), 64'd4095);
        check("unf_no_ovf", 64'(o_ovf), 64'd0);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1 check("unf_cleared", 64'(o_unf), 64'd0);

        tick();
        op_valid = 1'b1;
        op_push  = 1'b1;
        op_words = 2'd2;
        tick();
        op_valid = 1'b0;
        #1;
        check("abort_w0_en", 64'(o_en), 64'd1);
        check("abort_w0_addr", 64'(o_addr), 64'd4095);
        rst0 = 1'b0;
        tick();
        rst0 = 1'b1;
        #1;
        check("abort_sp", 64'(o_sp), 64'd4095);
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_done", 64'(o_done), 64'd0);
        check("abort_mem_en", 64'(o_en), 64'd0);
        tick();
        #1 check("abort_no_late_done", 64'(o_done), 64'd0);

        sel   = 1'b1;
        m_lim = 4094;
        m_sp  = ADDR_W'(INIT);
        rst1  = 1'b1;
        tick();
        #1 check("d1_rst_sp", 64'(o_sp), 64'd4095);
        run_op(1'b1, 1, 0);
        check("d1_pre_sp", 64'(o_sp), 64'd4094);
        run_op(1'b1, 2, 0);
        check("ovf_set", 64'(o_ovf), 64'd1);
        check("ovf_sp", 64'(o_sp), 64'd4093);
        check("ovf_no_unf", 64'(o_unf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- Parametrised stack-pointer engine for the memory stage. It owns the architectural SP and sequences single- and multi-word stack accesses, one word per cycle: CALL/PUSH are 1 word, RET/POP are 1 word, INT pushes PC+flags (2 words), and RTI pops 2 words.
- Generates the per-word memory address and holds off on a memory stall.
- Flags stack overflow and underflow against configurable bounds.
- Replaces the fixed 32-bit, reset-to-constant SP register with a sequenced, bounds-checked unit.

Parameters:
- ADDR_W, 32, width of SP and memory address
- SP_INIT, 4095, SP value after reset (empty-stack top)
- SP_LIMIT, 0, lowest legal push address
- MAX_WORDS, 2, maximum words per operation
- CNT_W, 2, width of word-count fields (must hold MAX_WORDS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 at a rising clk edge resets)
- op_valid  in  1  request present
- op_push  in  1  1 = push sequence, 0 = pop sequence
- op_words  in  CNT_W  words in the sequence, 1..MAX_WORDS
- mem_stall  in  1  memory not ready; hold the current word
- err_clr  in  1  clears sticky error flags
- op_ready  out  1  unit can accept a request this cycle
- sp  out  ADDR_W  current architectural SP
- mem_addr  out  ADDR_W  address for the current word
- mem_en  out  1  mem_addr valid this cycle
- mem_we  out  1  1 = write (push), 0 = read (pop)
- word_idx  out  CNT_W  index of the current word, 0-based
- done  out  1  one-cycle pulse when the last word completes
- ovf  out  1  sticky: push attempted below SP_LIMIT
- unf  out  1  sticky: pop attempted above SP_INIT

Behaviour:
- Reset (rst==0 at edge): state=IDLE, sp=SP_INIT, word_idx=0, ovf=0, unf=0, done=0. mem_en, mem_we and mem_addr are 0 (combinational from IDLE). Reset mid-sequence aborts it and discards the remaining words.

- States: IDLE, ACCESS.
- op_ready = (state==IDLE).

- Acceptance:
  - A request is accepted when op_valid && op_ready.
  - op_words==0 is treated as 1.
  - op_words>MAX_WORDS is clamped to MAX_WORDS.
  - op_push and the word count are latched on acceptance.
  - Transition IDLE->ACCESS on the edge after acceptance; mem_en first asserts in ACCESS, so latency is 1 cycle.

- Push convention is post-decrement: mem_addr=sp, mem_we=1. On a non-stalled cycle, sp<=sp-1.
- Pop convention is pre-increment: mem_addr=sp+1, mem_we=0. On a non-stalled cycle, sp<=sp+1.
- All arithmetic is modulo 2^ADDR_W. The bounds checks below prevent wrap in legal use.

- Bounds:
  - Push word with sp<SP_LIMIT: mem_en=0 for that word, sp unchanged, ovf<=1.
  - Pop word with sp>=SP_INIT: mem_en=0, sp unchanged, unf<=1.
  - In both cases the sequence still advances (word_idx increments, done still fires), so the pipeline never hangs.

- Stall: mem_stall=1 in ACCESS holds sp, word_idx and mem_addr. mem_en stays asserted. No error is evaluated twice.
- Sequencing: on each non-stalled ACCESS cycle, word_idx increments. On the last word, done=1 for that same cycle and the unit returns to IDLE on the next edge. word_idx resets to 0.
- Back-to-back: op_ready rises the cycle after done, so there is one IDLE bubble minimum between sequences.

- Errors:
  - err_clr=1 clears ovf/unf on the next edge.
  - If a new error occurs in the same cycle as err_clr, the set wins.
  - ovf/unf do not affect sp beyond the suppressed word.

- sp is observable every cycle and updates only as described above.

Decomposition:
- Shared package stack_defs:
  - state encoding constants ST_IDLE/ST_ACCESS
  - default SP_INIT/SP_LIMIT
  - word-count constants for INT/RTI (2) and CALL/RET (1), used by the decoder
- Natural sub-module: sp_bound_check, combinational. Takes sp, direction and bounds; returns the next sp, mem_addr and the error strobe. Instantiated once.

Test Plan:
- Reset: hold rst=0 for 2 clocks, release -> sp=4095, op_ready=1, ovf=unf=0, mem_en=0.
- Push 1 word from 4095 -> next cycle mem_en=1, mem_we=1, mem_addr=4095, done=1; following cycle sp=4094, op_ready=1.
- INT push 2 words with mem_stall=1 on word 0 for 3 cycles:
  - mem_addr stays 4094 with mem_en held while stalled.
  - Then 4094, 4093 with word_idx 0, 1.
  - done on word 1; final sp=4092.
- RTI pop 2 words from sp=4092 -> mem_addr 4093, then 4094, mem_we=0; sp=4094, done pulse.
- Underflow: pop 1 at sp=4095 -> mem_en=0, unf=1, sp=4095, done=1. Then err_clr=1 -> unf=0.
- Overflow and reset mid-operation:
  - With SP_LIMIT=4094, push 2 from 4094: word 0 writes 4094; word 1 sees sp=4093 -> ovf=1, sp stays 4093.
  - Separately, rst=0 asserted during word 0 of a 2-word push -> sp=4095, state IDLE, no done pulse.
